// File: rtl/hex_display_scanner.sv
// Time-multiplexed hex driver for a common-anode seven-segment display (all outputs active-low).
// Optional build macro HEX_DISPLAY_LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module hex_display_scanner #(
    parameter int WIDTH       = 16,
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK       = 1000
) (
    input  logic                 clk_100MHz,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     value,
    output logic [WIDTH/4-1:0]   an,
    output logic [6:0]           seg,
    output logic                 dp
);

    localparam int DIGITS = WIDTH / 4;
    localparam int CNT_W  = $clog2(REFRESH_DIV);
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0]  snap_q, snap_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [6:0]        seg_q, seg_d;

    logic [DIGITS-1:0] lead_zero;
    logic [3:0]        digit;
    logic              show;

    function automatic logic [6:0] hex_seg(input logic [3:0] d);
        case (d)
            4'h0: hex_seg = 7'b1000000;
            4'h1: hex_seg = 7'b1111001;
            4'h2: hex_seg = 7'b0100100;
            4'h3: hex_seg = 7'b0110000;
            4'h4: hex_seg = 7'b0011001;
            4'h5: hex_seg = 7'b0010010;
            4'h6: hex_seg = 7'b0000010;
            4'h7: hex_seg = 7'b1111000;
            4'h8: hex_seg = 7'b0000000;
            4'h9: hex_seg = 7'b0010000;
            4'hA: hex_seg = 7'b0001000;
            4'hB: hex_seg = 7'b0000011;
            4'hC: hex_seg = 7'b1000110;
            4'hD: hex_seg = 7'b0100001;
            4'hE: hex_seg = 7'b0000110;
            default: hex_seg = 7'b0001110;
        endcase
    endfunction

    // value is captured only on the last cycle of a frame, so a frame never mixes two values.
    always_comb begin
        cnt_d  = cnt_q + CNT_W'(1);
        idx_d  = idx_q;
        snap_d = snap_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d  = '0;
                snap_d = value;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

`ifdef HEX_DISPLAY_LEADING_ZERO_BLANK_EN
    logic upper_zero;

    // A digit is leading-zero when it and every digit above it are zero; digit 0 is never suppressed.
    always_comb begin
        lead_zero  = '0;
        upper_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            upper_zero   = upper_zero & (snap_q[4*k +: 4] == 4'h0);
            lead_zero[k] = upper_zero;
        end
    end
`else
    assign lead_zero = '0;
`endif

    always_comb begin
        an_d  = '1;
        seg_d = 7'b1111111;
        digit = 4'h0;
        show  = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                digit = snap_q[4*k +: 4];
                show  = (cnt_q >= CNT_BLANK) && !lead_zero[k];
                if (show) begin
                    an_d[k] = 1'b0;
                end
            end
        end
        if (show) begin
            seg_d = hex_seg(digit);
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            snap_q <= '0;
            an_q   <= '1;
            seg_q  <= 7'b1111111;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            snap_q <= snap_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = 1'b1;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Bench for hex_display_scanner with a short refresh divider; expected display stream is queued
// slot by slot and compared every cycle by an independent monitor.
module tb_hex_display_scanner;

    localparam int WIDTH = 16;
    localparam int RDIV  = 8;
    localparam int BLNK  = 2;
    localparam int LIT   = RDIV - BLNK;

    logic        clk_100MHz = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    logic [11:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          step     = 0;

    always #5 clk_100MHz = ~clk_100MHz;

    hex_display_scanner #(
        .WIDTH(WIDTH),
        .REFRESH_DIV(RDIV),
        .BLANK(BLNK)
    ) dut (
        .clk_100MHz(clk_100MHz),
        .rst(rst),
        .value(value),
        .an(an),
        .seg(seg),
        .dp(dp)
    );

    function automatic logic [6:0] hex_seg(input logic [3:0] d);
        case (d)
            4'h0: hex_seg = 7'b1000000;
            4'h1: hex_seg = 7'b1111001;
            4'h2: hex_seg = 7'b0100100;
            4'h3: hex_seg = 7'b0110000;
            4'h4: hex_seg = 7'b0011001;
            4'h5: hex_seg = 7'b0010010;
            4'h6: hex_seg = 7'b0000010;
            4'h7: hex_seg = 7'b1111000;
            4'h8: hex_seg = 7'b0000000;
            4'h9: hex_seg = 7'b0010000;
            4'hA: hex_seg = 7'b0001000;
            4'hB: hex_seg = 7'b0000011;
            4'hC: hex_seg = 7'b1000110;
            4'hD: hex_seg = 7'b0100001;
            4'hE: hex_seg = 7'b0000110;
            default: hex_seg = 7'b0001110;
        endcase
    endfunction

    task automatic push_dark(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({1'b1, 4'b1111, 7'b1111111});
    endtask

    // One slot: dark window, then `lit` cycles of digit k of v (or dark if suppressed).
    task automatic push_slot(input int k, input logic [15:0] v, input int lit);
        logic [3:0]  a;
        logic [3:0]  d;
        logic [15:0] upper;
        logic        vis;
        a        = 4'b1111;
        a[k]     = 1'b0;
        d        = v[4*k +: 4];
        upper    = v >> (4 * k);
        vis      = 1'b1;
`ifdef HEX_DISPLAY_LEADING_ZERO_BLANK_EN
        vis      = (k == 0) || (upper != 16'h0000);
`endif
        push_dark(BLNK);
        for (int i = 0; i < lit; i++) begin
            if (vis) exp_q.push_back({1'b1, a, hex_seg(d)});
            else     exp_q.push_back({1'b1, 4'b1111, 7'b1111111});
        end
    endtask

    task automatic push_frame(input logic [15:0] v);
        for (int k = 0; k < 4; k++) push_slot(k, v, LIT);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_100MHz);
            #1;
        end
    endtask

    always @(negedge clk_100MHz) begin : monitor
        logic [11:0] e;
        logic [11:0] got;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {dp, an, seg};
            step++;
            n_checks++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL out_step%0d: got dp=%b an=%b seg=%b, want dp=%b an=%b seg=%b",
                         step, got[11], got[10:7], got[6:0], e[11], e[10:7], e[6:0]);
            end
            n_checks++;
            if (!$onehot0(~an)) begin
                n_fail++;
                $display("FAIL one_anode step%0d: got an=%b, want at most one low bit", step, an);
            end
        end
    end

    initial begin
        rst   = 1'b1;
        value = 16'h1234;
        tick(1);
        push_dark(3);
        tick(2);
        rst = 1'b0;

        push_frame(16'h0000);
        push_frame(16'h1234);
        push_frame(16'h1234);
        push_frame(16'hABCD);
        tick(82);
        value = 16'hABCD;

        // Frame cut short by a reset landing on idx=2, cnt=5.
        push_slot(0, 16'hABCD, LIT);
        push_slot(1, 16'hABCD, LIT);
        push_slot(2, 16'hABCD, 3);
        push_dark(1);
        tick(67);
        rst = 1'b1;
        tick(1);
        rst   = 1'b0;
        value = 16'h89EF;

        push_frame(16'h0000);
        push_frame(16'h89EF);
        push_frame(16'h89EF);
        push_frame(16'h5670);
        push_frame(16'h5670);
        push_frame(16'h0042);
        push_frame(16'h0042);
        push_frame(16'h0000);
        tick(64);
        value = 16'h5670;
        tick(64);
        value = 16'h0042;
        tick(64);
        value = 16'h0000;
        tick(64);
        tick(1);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hex_display_scanner.md
Name: hex_display_scanner

Overview:
- Downstream consumer of the switch-driven shift register's parallel output.
- Time-multiplexes a WIDTH-bit value onto a common-anode multi-digit seven-segment display as hexadecimal digits.
- Owns its own refresh counter, digit index, frame snapshot and anti-ghosting blanking window.
- Outputs drive the board display pins directly.

Parameters:
- WIDTH, 16: input value width; must be a multiple of 4 and at least 4. DIGITS = WIDTH/4.
- REFRESH_DIV, 100000: clock cycles per digit slot (1 kHz digit rate at 100 MHz); must be at least 2.
- BLANK, 1000: cycles at the start of each slot with all anodes off; must satisfy 0 <= BLANK < REFRESH_DIV.

Ports:
- clk_100MHz  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- value  input  WIDTH  binary value to display; digit k = value[4k+3:4k], where digit 0 is the rightmost digit.
- an  output  DIGITS  anode enables, active-low; an[k] selects digit k.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low; held at 1 (off).

Behaviour:
- Reset (rst high at a clock edge):
  - cnt = 0, idx = 0, snap = 0.
  - an = all 1, seg = 7'b1111111, dp = 1.
  - Reset asserted mid-frame aborts the frame; scanning restarts at digit 0.
- Refresh counter:
  - cnt counts 0..REFRESH_DIV-1.
  - At cnt == REFRESH_DIV-1: cnt wraps to 0 and idx advances.
  - idx wraps from DIGITS-1 to 0.
- Frame snapshot:
  - snap <= value only on the cycle where cnt == REFRESH_DIV-1 and idx == DIGITS-1, i.e. the last cycle of a frame.
  - A frame therefore never mixes digits from two different values.
  - The first frame after reset displays all zeros.
- Output registers: an, seg and dp are registered from the current-cycle (cnt, idx, snap), giving one cycle of latency.
  - If cnt < BLANK: an = all 1 and seg = 7'b1111111.
  - Otherwise: an = all 1 except an[idx] = 0, and seg = hex decode of snap[4*idx+3:4*idx].
- Hex decode (seg, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Timing:
  - Exactly one anode is low at any time outside the blanking window; zero anodes are low during it.
  - Per slot: BLANK cycles dark, then REFRESH_DIV-BLANK cycles lit.
  - Frame period = DIGITS*REFRESH_DIV cycles.
- Changes on value between snapshots are ignored. value is sampled only at the snapshot edge, so no synchronisation is required here.

Optional Feature:
- Macro: HEX_DISPLAY_LEADING_ZERO_BLANK_EN.
- Defined:
  - Leading zero digits of snap are suppressed: their anode stays 1 and seg = 1111111 for their whole slot.
  - Digit 0 is always shown, so 0x0000 displays as a single "0".
  - Slot timing is unchanged.
- Undefined: all DIGITS digits are always shown, including leading zeros.

Test Plan:
All scenarios use WIDTH=16, REFRESH_DIV=8, BLANK=2.
1. rst held 3 cycles with value=16'h1234 -> an=4'b1111, seg=7'b1111111, dp=1 during reset. The first frame after release shows "0000": an[0] is low for 6 cycles with seg=1000000.
2. value=16'h1234 held -> from the second frame:
   - an sequence 1110, 1101, 1011, 0111, each slot preceded by 2 cycles of an=1111.
   - seg per slot 0011001 ("4"), 0110000 ("3"), 0100100 ("2"), 1111001 ("1").
   - Frame period is 32 cycles.
3. value changes 16'h1234 -> 16'hABCD during slot 2 -> remaining slots of that frame still show "1" and "2". The next frame shows D, C, b, A (0100001, 1000110, 0000011, 0001000).
4. rst pulsed for 1 cycle while idx=2, cnt=5 -> on the following cycle an=1111. Scanning resumes at digit 0 with snap=0, i.e. "0000" for one frame.
5. value=16'h89EF and then 16'h5670, each held for 2 frames -> every seg code matches the decode table. Each an pattern has at most one zero bit.
6. With HEX_DISPLAY_LEADING_ZERO_BLANK_EN defined:
   - value=16'h0042 -> an[3] and an[2] stay 1 throughout; digits 1 and 0 show "4" and "2".
   - value=16'h0000 -> only an[0] goes low, with seg=1000000.
